lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store bus controller that sits directly upstream of the load width/sign-extension stage in the single-cycle RV32I core.
- Accepts one access per instruction from execute, runs a ready-handshake transaction on the word-addressed data memory, and stalls the core until the transaction completes.
- Aligns store data and byte enables to the addressed lanes.
- Returns the loaded word right-justified (addressed byte/half at bit 0) for extension by the next stage.
- Detects misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in ACCESS waiting for mem_ready before the access is aborted; legal range 1..255.

Ports:
- clk  in  1  core clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage requests an access; held high until done.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (rs2).
- busy  out  1  stall to core: req_valid & ~done.
- done  out  1  one-cycle completion pulse.
- rdata_raw  out  32  right-justified load word, fed to the width-extension stage.
- fault_align  out  1  qualifies done: misaligned or illegal funct3.
- fault_timeout  out  1  qualifies done: no mem_ready within TIMEOUT_CYCLES.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  32  word address; [1:0] always 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  memory accepts/completes the access this cycle.
- mem_rdata  in  32  read data; valid when mem_ready = 1 on a read.

Behaviour:
- Reset (async, rst_n = 0):
  - State IDLE.
  - All outputs 0, including rdata_raw, mem_* and both faults.
  - Timeout counter 0.
  - Reset mid-ACCESS drops mem_req immediately; the transaction is abandoned.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE & req_valid: check legality.
  - Illegal funct3 (011, 110, 111; or 100/101 with req_we = 1): go to ERR.
  - Misaligned H/HU with addr[0] = 1: go to ERR.
  - Misaligned W with addr[1:0] != 00: go to ERR.
  - Otherwise: register mem_addr = {addr[31:2], 2'b00}, mem_be, mem_wdata, mem_we and addr[1:0]; clear the counter; go to ACCESS.
- Byte enables and store data:
  - B/BU: mem_be = 0001 << addr[1:0]; mem_wdata = the byte replicated x4.
  - H/HU: mem_be = 0011 << addr[1:0]; mem_wdata = the half replicated x2.
  - W: mem_be = 1111; mem_wdata = req_wdata.
  - Loads drive the same mem_be pattern.
- ACCESS:
  - mem_req = 1; all mem_* outputs held stable until mem_ready is sampled high.
  - mem_ready = 1 on a load: rdata_raw <= mem_rdata >> (8*addr[1:0]), zero-filled.
  - mem_ready = 1 on a store: rdata_raw unchanged.
  - On mem_ready = 1, go to RESP and deassert mem_req the next cycle.
  - The counter increments each ACCESS cycle without ready. When it reaches TIMEOUT_CYCLES: deassert mem_req, set the timeout flag, go to RESP; rdata_raw unchanged.
  - mem_ready and timeout in the same cycle: ready wins, no fault.
- RESP:
  - done = 1 for exactly one cycle; fault_timeout as latched.
  - Go to IDLE.
- ERR:
  - done = 1 and fault_align = 1 for one cycle; mem_req never asserted.
  - Go to IDLE.
- Fault flags are 0 whenever done = 0.
- Latency from accept to done is 2 + N cycles, where N = wait cycles before ready. Minimum is 2 (accept, ACCESS with ready, RESP).
- req_valid still high in IDLE after done is treated as a new request (back-to-back accesses allowed).
- rdata_raw holds the last completed load value indefinitely.
- mem_ready outside ACCESS is ignored.
- Changes to req_* while in ACCESS/RESP are ignored; the registered copies are used.

Decomposition:
- Shared package lsu_pkg contains:
  - state enum {IDLE, ACCESS, RESP, ERR};
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the timeout counter width (8).
- One combinational sub-module, store_lane_align: inputs funct3, addr[1:0], wdata; outputs be[3:0], wdata_rep[31:0], legal. Also used for alignment checking.
- FSM, counter and read shifter live in lsu_mem_ctrl.

Test Plan:
- SB addr 0x103, wdata 0x000000A5, ready on first ACCESS cycle -> mem_addr 0x100, mem_be 1000, mem_wdata 0xA5A5A5A5, done 2 cycles after accept, no faults.
- LH addr 0x202, mem_rdata 0xBEEF1234, ready after 3 wait cycles -> rdata_raw 0x0000BEEF, done on cycle 5 after accept.
- LW addr 0x301 -> ERR: done = 1 and fault_align = 1 the cycle after accept, mem_req stays 0; funct3 011 gives the same response.
- LW with mem_ready held 0 and TIMEOUT_CYCLES = 16 -> mem_req drops after 16 ACCESS cycles, done with fault_timeout = 1, rdata_raw keeps its prior value.
- Two back-to-back loads LBU 0x401 and LW 0x404, ready immediate -> second accepted the cycle after the first done, rdata_raw updated twice, busy low only between done and the next req_valid.
- rst_n pulsed low mid-ACCESS -> mem_req and all outputs 0 asynchronously, FSM in IDLE, no done pulse.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 8;

endpackage

// File: rtl/lsu_mem_ctrl_store_lane_align.sv
// Lane placement of store data / byte enables, plus width-vs-address legality.
module store_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        legal
);

  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0;
    legal     = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
        legal     = 1'b1;
      end
      F3_H, F3_HU: begin
        be        = 4'b0011 << addr;
        wdata_rep = {2{wdata[15:0]}};
        legal     = ~addr[0];
      end
      F3_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        legal     = (addr == 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store bus controller: one ready-handshake memory access per request,
// with alignment faults, bus timeout and right-justified load data.
//
// state  | meaning
// IDLE   | waiting for req_valid; legality checked on accept
// ACCESS | mem_req high, waiting for mem_ready or timeout
// RESP   | done pulse, fault_timeout qualified
// ERR    | done pulse with fault_align, bus never touched
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata_raw,
  output logic        fault_align,
  output logic        fault_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             to_flag;
  logic [1:0]       off;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic             lane_legal;
  logic             req_legal;
  logic             timeout_hit;

  store_lane_align u_align (
    .funct3    (req_funct3),
    .addr      (req_addr[1:0]),
    .wdata     (req_wdata),
    .be        (be_c),
    .wdata_rep (wdata_c),
    .legal     (lane_legal)
  );

  // Unsigned load widths have no store form.
  assign req_legal   = lane_legal &
                       ~(req_we & ((req_funct3 == F3_BU) | (req_funct3 == F3_HU)));
  assign timeout_hit = ((cnt + CNT_ONE) == TO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_legal ? ACCESS : ERR;
      ACCESS:  if (mem_ready || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= 32'h0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
      mem_we    <= 1'b0;
      off       <= 2'b00;
      cnt       <= '0;
      to_flag   <= 1'b0;
      rdata_raw <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_legal) begin
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_be    <= be_c;
            mem_wdata <= wdata_c;
            mem_we    <= req_we;
            off       <= req_addr[1:0];
            cnt       <= '0;
            to_flag   <= 1'b0;
          end
        end
        ACCESS: begin
          // Ready takes priority over a coincident timeout.
          if (mem_ready) begin
            if (!mem_we) rdata_raw <= mem_rdata >> {off, 3'b000};
          end else begin
            cnt <= cnt + CNT_ONE;
            if (timeout_hit) to_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req       = (state == ACCESS);
  assign done          = (state == RESP) || (state == ERR);
  assign fault_align   = (state == ERR);
  assign fault_timeout = (state == RESP) && to_flag;
  // Held low while in reset so every output is quiet regardless of req_valid.
  assign busy          = req_valid & ~done & rst_n;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus random accesses
// against a transaction-level reference model.
module tb_lsu_mem_ctrl;

  localparam int TO = 16;

  logic        clk, rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        busy, done;
  logic [31:0] rdata_raw;
  logic        fault_align, fault_timeout;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int          ncomp = 0;
  int          nfail = 0;
  logic [31:0] exp_rdata;
  bit          after_done;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .busy          (busy),
    .done          (done),
    .rdata_raw     (rdata_raw),
    .fault_align   (fault_align),
    .fault_timeout (fault_timeout),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncomp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 1'b1;
      3'd1:    return (a % 2) == 0;
      3'd2:    return (a % 4) == 0;
      3'd4:    return !we;
      3'd5:    return !we && ((a % 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ref_size(input logic [2:0] f3);
    int s;
    s = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    return s;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << ref_size(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (ref_size(f3))
      1:       return {4{w[7:0]}};
      2:       return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      step();
      after_done = 1'b0;
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_mem_req", mem_req, 0);
      chk("idle_rdata_hold", rdata_raw, exp_rdata);
    end
  endtask

  // One access from accept to done; bus answers after `waits` ACCESS cycles.
  task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
    bit legal, got;
    int lat, cyc, wc, acc;
    legal = ref_legal(we, f3, addr);
    lat   = !legal ? 1 : (waits < TO ? 2 + waits : TO + 1);
    if (after_done) lat++;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    mem_ready  = 1'b0;
    mem_rdata  = $urandom;
    cyc = 0; wc = 0; acc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      step();
      cyc++;
      mem_ready = 1'b0;
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        chk("busy_pending", busy, 1);
        if (mem_req === 1'b1) begin
          acc++;
          chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
          chk("mem_be", mem_be, ref_be(f3, addr));
          chk("mem_wdata", mem_wdata, ref_wdata(f3, wdata));
          chk("mem_we", mem_we, we);
          req_addr   = $urandom;
          req_wdata  = $urandom;
          req_funct3 = 3'($urandom);
          req_we     = 1'($urandom);
          if (wc == waits) begin
            mem_ready = 1'b1;
            mem_rdata = rdata;
          end else begin
            wc++;
            mem_rdata = $urandom;
          end
        end
      end
    end
    chk("done_seen", got, 1);
    chk("latency", cyc, lat);
    chk("access_cycles", acc, legal ? (waits < TO ? waits + 1 : TO) : 0);
    chk("fault_align", fault_align, !legal);
    chk("fault_timeout", fault_timeout, legal && waits >= TO);
    chk("busy_at_done", busy, 0);
    if (legal && !we && waits < TO) exp_rdata = rdata >> (8 * (addr % 4));
    chk("rdata_raw", rdata_raw, exp_rdata);
    req_valid  = 1'b0;
    after_done = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    exp_rdata = 32'h0; after_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_rdata", rdata_raw, 0);
    chk("rst_faults", {fault_align, fault_timeout}, 0);
    rst_n = 1'b1;
    idle(2);

    // Byte store to the top lane, immediate ready
    access(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0);
    idle(1);
    // Halfword load from upper half after 3 wait cycles
    access(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'hBEEF_1234, 3);
    chk("lh_value", rdata_raw, 32'h0000_BEEF);
    idle(2);
    // Misaligned word and illegal funct3 codes
    access(1'b0, 3'b010, 32'h0000_0301, 32'h0, 32'h0, 0);
    idle(1);
    access(1'b0, 3'b011, 32'h0000_0300, 32'h0, 32'h0, 0);
    idle(1);
    access(1'b1, 3'b100, 32'h0000_0300, 32'h0, 32'h0, 0);
    idle(1);
    access(1'b0, 3'b101, 32'h0000_0303, 32'h0, 32'h0, 0);
    idle(1);
    // Timeout vs. ready on the final allowed cycle
    access(1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h1357_9BDF, TO);
    idle(1);
    access(1'b0, 3'b010, 32'h0000_0604, 32'h0, 32'h2468_ACE0, TO - 1);
    idle(1);
    // Back-to-back loads
    access(1'b0, 3'b100, 32'h0000_0401, 32'h0, 32'h1122_3344, 0);
    chk("lbu_value", rdata_raw, 32'h0011_2233);
    access(1'b0, 3'b010, 32'h0000_0404, 32'h0, 32'hCAFE_F00D, 0);
    chk("lw_value", rdata_raw, 32'hCAFE_F00D);
    idle(2);

    for (int n = 0; n < 60; n++) begin
      int waits;
      waits = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(TO - 2, TO + 1);
      access(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, waits);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);

    // Reset in the middle of an access
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0500;
    mem_ready = 1'b0;
    repeat (3) step();
    chk("pre_rst_mem_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_mem_req", mem_req, 0);
    chk("async_done", done, 0);
    chk("async_busy", busy, 0);
    chk("async_mem_addr", mem_addr, 0);
    chk("async_mem_be", mem_be, 0);
    chk("async_mem_wdata", mem_wdata, 0);
    chk("async_mem_we", mem_we, 0);
    chk("async_rdata", rdata_raw, 0);
    chk("async_faults", {fault_align, fault_timeout}, 0);
    exp_rdata = 32'h0;
    req_valid = 1'b0;
    step();
    rst_n = 1'b1;
    after_done = 1'b0;
    idle(3);
    access(1'b0, 3'b001, 32'h0000_0702, 32'h0, 32'h89AB_CDEF, 1);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
